// File: rtl/output_port_arbiter.sv
// Output-port arbiter: four input ports compete round-robin for one downstream
// link; the winner owns the link until its tail flit or a forced release.
module output_port_arbiter #(
  parameter int flitWidth         = 12,
  parameter int modifiedFlitWidth = 14,
  parameter int maxFlits          = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [modifiedFlitWidth-1:0] inFlit1,
  input  logic [modifiedFlitWidth-1:0] inFlit2,
  input  logic [modifiedFlitWidth-1:0] inFlit3,
  input  logic [modifiedFlitWidth-1:0] inFlit4,
  input  logic                         outBlock,
  output logic [flitWidth-1:0]         outputData,
  output logic                         outValid,
  output logic                         portBlock1,
  output logic                         portBlock2,
  output logic                         portBlock3,
  output logic                         portBlock4,
  output logic [1:0]                   grant,
  output logic                         busy
);

  localparam int              CW        = $clog2(maxFlits + 1);
  localparam logic [CW-1:0]   MAX_CNT   = CW'(maxFlits);
  localparam logic [CW-1:0]   ONE_CNT   = CW'(1);
  localparam int              VALID_BIT = modifiedFlitWidth - 1;
  localparam int              TAIL_BIT  = modifiedFlitWidth - 2;
  localparam int              HEAD_BIT  = flitWidth - 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                 state, state_nxt;
  logic [1:0]             rr_ptr, rr_nxt, grant_nxt;
  logic [CW-1:0]          flit_count, count_nxt;
  logic [flitWidth-1:0]   data_nxt;
  logic                   valid_nxt, busy_nxt;

  logic [modifiedFlitWidth-1:0] flit [4];
  logic [3:0]             in_valid, in_tail, in_head, request;
  logic [3:0]             port_block;
  logic [1:0]             winner, rr_idx, sel_port;
  logic                   found, sel_live;

  assign flit[0] = inFlit1;
  assign flit[1] = inFlit2;
  assign flit[2] = inFlit3;
  assign flit[3] = inFlit4;

  for (genvar i = 0; i < 4; i++) begin : g_decode
    assign in_valid[i] = flit[i][VALID_BIT];
    assign in_tail[i]  = flit[i][TAIL_BIT];
    assign in_head[i]  = flit[i][HEAD_BIT];
  end

  assign request = in_valid & in_head;

  // Round-robin search starting at rr_ptr, wrapping 3 -> 0.
  // NOTE: every variable written in an always_comb gets a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    rr_idx = rr_ptr;
    for (int k = 0; k < 4; k++) begin
      rr_idx = rr_ptr + 2'(k);
      if (!found && request[rr_idx]) begin
        winner = rr_idx;
        found  = 1'b1;
      end
    end
  end

  // While reset is held there is no winner or owner, so every valid input stalls.
  assign sel_port = (state == LOCKED) ? grant : winner;
  assign sel_live = !reset && ((state == LOCKED) || found);

  always_comb begin
    port_block = '0;
    for (int n = 0; n < 4; n++) begin
      port_block[n] = in_valid[n] && (!(sel_live && (sel_port == 2'(n))) || outBlock);
    end
  end

  assign portBlock1 = port_block[0];
  assign portBlock2 = port_block[1];
  assign portBlock3 = port_block[2];
  assign portBlock4 = port_block[3];

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    grant_nxt = grant;
    count_nxt = flit_count;
    data_nxt  = outputData;
    valid_nxt = 1'b0;
    busy_nxt  = busy;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (found && !outBlock) begin
          grant_nxt = winner;
          busy_nxt  = 1'b1;
          data_nxt  = flit[winner][flitWidth-1:0];
          valid_nxt = 1'b1;
          count_nxt = ONE_CNT;
          rr_nxt    = winner + 2'd1;
          // A single-flit packet (or maxFlits of 1) never enters LOCKED.
          if (!in_tail[winner] && (ONE_CNT != MAX_CNT)) state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (in_valid[grant] && !outBlock) begin
          data_nxt  = flit[grant][flitWidth-1:0];
          valid_nxt = 1'b1;
          count_nxt = flit_count + ONE_CNT;
          if (in_tail[grant] || (count_nxt == MAX_CNT)) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= 2'd0;
      flit_count <= '0;
      outputData <= '0;
      outValid   <= 1'b0;
      grant      <= 2'd0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      rr_ptr     <= rr_nxt;
      flit_count <= count_nxt;
      outputData <= data_nxt;
      outValid   <= valid_nxt;
      grant      <= grant_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Bench for output_port_arbiter: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a packet-level reference model.
module tb_output_port_arbiter;

  localparam int FW   = 12;
  localparam int MW   = 14;
  localparam int MAXF = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [MW-1:0] in_flit [4];
  logic          out_block;
  logic [FW-1:0] output_data;
  logic          out_valid, busy;
  logic [1:0]    grant;
  logic          pb1, pb2, pb3, pb4;
  logic [3:0]    pb_vec;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  output_port_arbiter #(
    .flitWidth(FW), .modifiedFlitWidth(MW), .maxFlits(MAXF)
  ) dut (
    .clk(clk), .reset(reset),
    .inFlit1(in_flit[0]), .inFlit2(in_flit[1]), .inFlit3(in_flit[2]), .inFlit4(in_flit[3]),
    .outBlock(out_block), .outputData(output_data), .outValid(out_valid),
    .portBlock1(pb1), .portBlock2(pb2), .portBlock3(pb3), .portBlock4(pb4),
    .grant(grant), .busy(busy)
  );

  assign pb_vec = {pb4, pb3, pb2, pb1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] mk_flit(input logic v, input logic t, input logic [FW-1:0] raw);
    return {v, t, raw};
  endfunction

  task automatic clear_inputs();
    for (int p = 0; p < 4; p++) in_flit[p] = '0;
    out_block = 1'b0;
  endtask

  // Leaves the bench one time unit after a rising edge with reset released.
  task automatic pulse_reset();
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit                  do_reset;
    logic [3:0][MW-1:0]  f;
    logic                ob;
    logic [3:0]          pb;
    logic                ov;
    logic [FW-1:0]       od;
    logic                bz;
    logic [1:0]          gr;
  } vec_t;

  function automatic vec_t mkv(input bit r, input logic [MW-1:0] p1, input logic [MW-1:0] p2,
                               input logic [MW-1:0] p3, input logic [MW-1:0] p4, input logic ob,
                               input logic [3:0] pb, input logic ov, input logic [FW-1:0] od,
                               input logic bz, input logic [1:0] gr);
    vec_t v;
    v.do_reset = r;
    v.f[0] = p1; v.f[1] = p2; v.f[2] = p3; v.f[3] = p4;
    v.ob = ob; v.pb = pb; v.ov = ov; v.od = od; v.bz = bz; v.gr = gr;
    return v;
  endfunction

  localparam int NV = 15;
  vec_t vecs [NV];

  // ---------------- hand-sequence helper ----------------
  task automatic cycle(input int p, input logic [MW-1:0] f, input logic ob, input logic exp_pb,
                       input logic exp_ov, input logic [FW-1:0] exp_od, input logic exp_bz,
                       input string tag);
    clear_inputs();
    in_flit[p] = f;
    out_block  = ob;
    #1;
    check({tag, " portBlock"}, 32'(pb_vec[p]), 32'(exp_pb));
    @(posedge clk);
    #1;
    check({tag, " outValid"},   32'(out_valid),   32'(exp_ov));
    check({tag, " outputData"}, 32'(output_data), 32'(exp_od));
    check({tag, " busy"},       32'(busy),        32'(exp_bz));
  endtask

  // ---------------- packet-level reference model ----------------
  bit            m_locked;
  int            m_owner, m_rr, m_cnt;
  logic [FW-1:0] m_od;
  logic          m_ov, m_bz;
  logic [1:0]    m_gr;

  task automatic model_reset();
    m_locked = 0; m_owner = 0; m_rr = 0; m_cnt = 0;
    m_od = '0; m_ov = 0; m_bz = 0; m_gr = 0;
  endtask

  task automatic model_cycle(input logic [3:0][MW-1:0] f, input logic ob, output logic [3:0] pb);
    bit v [4];
    bit t [4];
    bit h [4];
    int win, sel;
    for (int p = 0; p < 4; p++) begin
      v[p] = f[p][MW-1];
      t[p] = f[p][MW-2];
      h[p] = f[p][FW-1];
    end
    win = -1;
    if (!m_locked) begin
      for (int k = 0; k < 4; k++) begin
        if (win < 0 && v[(m_rr + k) % 4] && h[(m_rr + k) % 4]) win = (m_rr + k) % 4;
      end
    end
    sel = m_locked ? m_owner : win;
    for (int n = 0; n < 4; n++) pb[n] = v[n] && ((n != sel) || ob);
    if (!m_locked) begin
      m_ov = 0;
      m_bz = 0;
      if (win >= 0 && !ob) begin
        m_od = f[win][FW-1:0];
        m_ov = 1; m_bz = 1;
        m_gr = 2'(win);
        m_owner = win;
        m_cnt = 1;
        m_rr = (win + 1) % 4;
        m_locked = !t[win] && (m_cnt < MAXF);
      end
    end else if (v[m_owner] && !ob) begin
      m_od = f[m_owner][FW-1:0];
      m_ov = 1;
      m_cnt++;
      if (t[m_owner] || m_cnt == MAXF) begin
        m_locked = 0;
        m_bz = 0;
      end
    end else begin
      m_ov = 0;
    end
  endtask

  initial begin
    logic [3:0][MW-1:0] rf;
    logic               rob;
    logic [3:0]         exp_pb;

    // Reset state, and blocking of valid inputs while reset is held.
    clear_inputs();
    #1 reset = 1'b1;
    in_flit[0] = mk_flit(1, 0, 12'h8AA);
    in_flit[2] = mk_flit(1, 0, 12'h155);
    #2;
    check("reset portBlock",  32'(pb_vec),      32'h5);
    check("reset outValid",   32'(out_valid),   32'h0);
    check("reset outputData", 32'(output_data), 32'h0);
    check("reset busy",       32'(busy),        32'h0);
    check("reset grant",      32'(grant),       32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    clear_inputs();

    // Single packet, non-head in IDLE, contention, single-flit, IDLE backpressure.
    vecs[0]  = mkv(1, mk_flit(1,0,12'h92B), '0, '0, '0, 0, 4'b0000, 1, 12'h92B, 1, 0);
    vecs[1]  = mkv(0, mk_flit(1,0,12'h721), '0, '0, '0, 0, 4'b0000, 1, 12'h721, 1, 0);
    vecs[2]  = mkv(0, mk_flit(1,1,12'h00F), '0, '0, '0, 0, 4'b0000, 1, 12'h00F, 0, 0);
    vecs[3]  = mkv(0, '0, '0, '0, '0, 0, 4'b0000, 0, 12'h00F, 0, 0);
    vecs[4]  = mkv(0, '0, '0, '0, mk_flit(1,0,12'h721), 0, 4'b1000, 0, 12'h00F, 0, 0);
    vecs[5]  = mkv(1, '0, mk_flit(1,0,12'h8A1), mk_flit(1,0,12'h8B2), '0, 0, 4'b0100, 1, 12'h8A1, 1, 1);
    vecs[6]  = mkv(0, '0, mk_flit(1,1,12'h0C3), mk_flit(1,0,12'h8B2), '0, 0, 4'b0100, 1, 12'h0C3, 0, 1);
    vecs[7]  = mkv(0, '0, '0, mk_flit(1,0,12'h8B2), '0, 0, 4'b0000, 1, 12'h8B2, 1, 2);
    vecs[8]  = mkv(0, '0, '0, mk_flit(1,1,12'h0D4), '0, 0, 4'b0000, 1, 12'h0D4, 0, 2);
    vecs[9]  = mkv(0, mk_flit(1,1,12'h801), '0, '0, mk_flit(1,1,12'h802), 0, 4'b0001, 1, 12'h802, 1, 3);
    vecs[10] = mkv(0, mk_flit(1,1,12'h801), '0, '0, '0, 0, 4'b0000, 1, 12'h801, 1, 0);
    vecs[11] = mkv(0, '0, '0, '0, '0, 0, 4'b0000, 0, 12'h801, 0, 0);
    vecs[12] = mkv(0, mk_flit(1,0,12'h8E5), '0, mk_flit(1,0,12'h8F6), '0, 1, 4'b0101, 0, 12'h801, 0, 0);
    vecs[13] = mkv(0, mk_flit(1,0,12'h8E5), '0, mk_flit(1,0,12'h8F6), '0, 0, 4'b0001, 1, 12'h8F6, 1, 2);
    vecs[14] = mkv(0, mk_flit(1,0,12'h8E5), '0, mk_flit(1,1,12'h0A7), '0, 0, 4'b0001, 1, 12'h0A7, 0, 2);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].do_reset) pulse_reset();
      for (int p = 0; p < 4; p++) in_flit[p] = vecs[i].f[p];
      out_block = vecs[i].ob;
      #1;
      check($sformatf("vec%0d portBlock", i), 32'(pb_vec), 32'(vecs[i].pb));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d outValid", i),   32'(out_valid),   32'(vecs[i].ov));
      check($sformatf("vec%0d outputData", i), 32'(output_data), 32'(vecs[i].od));
      check($sformatf("vec%0d busy", i),       32'(busy),        32'(vecs[i].bz));
      check($sformatf("vec%0d grant", i),      32'(grant),       32'(vecs[i].gr));
    end

    // Mid-packet backpressure followed by forced release at maxFlits.
    pulse_reset();
    cycle(0, mk_flit(1,0,12'h900), 0, 0, 1, 12'h900, 1, "bp head");
    cycle(0, mk_flit(1,0,12'h101), 0, 0, 1, 12'h101, 1, "bp body1");
    for (int s = 0; s < 3; s++) cycle(0, mk_flit(1,0,12'h102), 1, 1, 0, 12'h101, 1, "bp stall");
    for (int k = 2; k <= 7; k++)
      cycle(0, mk_flit(1,0,12'(12'h100 + k)), 0, 0, 1, 12'(12'h100 + k), (k == 7) ? 1'b0 : 1'b1, "fr body");
    for (int k = 8; k <= 10; k++)
      cycle(0, mk_flit(1,0,12'(12'h100 + k)), 0, 1, 0, 12'h107, 0, "fr blocked");

    // Reset asserted mid-packet, then a headless body flit must be refused.
    pulse_reset();
    cycle(1, mk_flit(1,0,12'hA00), 0, 0, 1, 12'hA00, 1, "rm head");
    cycle(1, mk_flit(1,0,12'h201), 0, 0, 1, 12'h201, 1, "rm body");
    in_flit[1] = mk_flit(1,0,12'h202);
    #2 reset = 1'b1;
    #1;
    check("rm async outValid",   32'(out_valid),   32'h0);
    check("rm async busy",       32'(busy),        32'h0);
    check("rm async outputData", 32'(output_data), 32'h0);
    check("rm async portBlock",  32'(pb_vec),      32'h2);
    @(posedge clk);
    #1 reset = 1'b0;
    cycle(1, mk_flit(1,0,12'h202), 0, 1, 0, 12'h000, 0, "rm after");
    cycle(1, mk_flit(1,0,12'h203), 0, 1, 0, 12'h000, 0, "rm after2");

    // Randomized traffic against the reference model.
    pulse_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 4; p++) begin
        rf[p] = {($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
                 11'($urandom)};
        in_flit[p] = rf[p];
      end
      rob = ($urandom_range(0, 3) == 0);
      out_block = rob;
      model_cycle(rf, rob, exp_pb);
      #1;
      check($sformatf("rand%0d portBlock", c), 32'(pb_vec), 32'(exp_pb));
      @(posedge clk);
      #1;
      check($sformatf("rand%0d outputs", c), {16'h0, out_valid, output_data, busy, grant},
            {16'h0, m_ov, m_od, m_bz, m_gr});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/output_port_arbiter.md
OUTPUT_PORT_ARBITER -- requirements
Module: output_port_arbiter

Interface
REQ-001 The block SHALL have parameters: flitWidth, default 12, raw flit width; modifiedFlitWidth, default 14, input-port flit width; maxFlits, default 8, maximum flits per packet before forced release.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset. Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- inFlit1..inFlit4  input  modifiedFlitWidth each  flits from input ports 1..4.
- outBlock  input  1  downstream backpressure; 1 = cannot accept a flit this cycle.
- outputData  output  flitWidth  registered flit to the downstream link.
- outValid  output  1  outputData holds a valid flit.
- portBlock1..portBlock4  output  1 each  backpressure to input ports 1..4; 1 = hold current flit.
- grant  output  2  index of the owning input (0..3 = port 1..4); meaningful only when busy=1.
- busy  output  1  an input currently owns the output.
REQ-003 The modified flit format SHALL be: bit 13 = valid, bit 12 = tail, bits 11:0 = raw flit. Raw bit 11 = 1 marks a head flit.

Function
REQ-004 The FSM SHALL have two states: IDLE and LOCKED.
REQ-005 In IDLE, a requester is any input with valid=1 and head bit=1. Valid flits without the head bit SHALL be ignored and blocked.
REQ-006 In IDLE with at least one requester and outBlock=0, the block SHALL grant round-robin, starting at the rrPointer index and searching upward with wrap 3->0. On the next edge it SHALL:
- go to LOCKED;
- set grant and busy=1;
- register the head's raw 12 bits into outputData with outValid=1;
- load flitCount with 1;
- set rrPointer to winner+1 mod 4.
REQ-007 In IDLE with outBlock=1, the block SHALL NOT grant, and rrPointer SHALL be unchanged.
REQ-008 In LOCKED, each cycle the owner presents valid=1 and outBlock=0, the block SHALL forward the owner's raw flit to outputData with outValid=1 on the next edge (one-cycle latency) and increment flitCount.
REQ-009 In LOCKED, if the owner presents valid=0 or outBlock=1, the block SHALL set outValid=0 next cycle and leave flitCount unchanged.
REQ-010 LOCKED SHALL return to IDLE on the edge that forwards a flit with tail=1, or the edge on which flitCount reaches maxFlits (forced release, even without a tail). busy SHALL clear on that same edge.
REQ-011 A tail flit arriving on the head cycle (a single-flit packet) SHALL be forwarded, and the block SHALL stay in IDLE. busy SHALL pulse high for one cycle, and rrPointer SHALL still advance.
REQ-012 In LOCKED, a valid flit with the head bit from the owner SHALL be forwarded as ordinary data. It SHALL NOT start a new packet.
REQ-013 portBlockN (combinational) SHALL be 1 when input N has valid=1 and either:
- it is not the grant winner or owner this cycle; or
- it is the owner or winner and outBlock=1.
Otherwise portBlockN SHALL be 0.
REQ-014 An input with valid=0 SHALL see portBlockN=0.
REQ-015 outputData SHALL hold its last value when outValid=0.
REQ-016 flitCount SHALL be wide enough for maxFlits and SHALL never wrap.

Reset
REQ-017 Reset SHALL act immediately, independent of clk, and set: state=IDLE, rrPointer=0, flitCount=0, outputData=0, outValid=0, grant=0, busy=0.
REQ-018 Reset asserted mid-packet SHALL abandon the packet. After release, the block SHALL require a new head flit before forwarding.
REQ-019 portBlock outputs during reset SHALL follow REQ-013 with state=IDLE and no grant, so every valid input is blocked.

Verification
REQ-020 Single packet: inFlit1 = 14'b10_100100101011 (head), then 14'b10_011100100001 (body), then 14'b11_000000001111 (tail), outBlock=0 -> outValid high for 3 consecutive cycles, each one cycle after its input, with outputData = 100100101011, 011100100001, 000000001111; busy falls after the tail; grant=0.
REQ-021 Contention: inputs 2 and 3 present heads simultaneously, rrPointer=0 -> port 2 wins (grant=1) and portBlock3=1 until port 2's tail; port 3 is granted the following cycle; rrPointer ends at 3.
REQ-022 Backpressure: outBlock=1 for 3 cycles mid-packet -> outValid=0 and portBlock of the owner=1 for those cycles; flitCount unchanged; forwarding resumes with no flit lost or duplicated.
REQ-023 Forced release: owner sends 10 body flits with no tail, maxFlits=8 -> exactly 8 flits forwarded, busy clears, and the 9th flit (no head bit) is blocked and not forwarded.
REQ-024 Reset mid-packet: assert reset after the 2nd flit -> outValid=0 and busy=0 immediately; after release, a body flit without a head is not forwarded.
REQ-025 Non-head in IDLE: inFlit4 = 14'b10_011100100001 with no head bit -> no grant, portBlock4=1, outValid stays 0.
